sha1_avalon_master: RTL and testbench

//  Avalon-MM master that drives the SHA-1 register-file slave. Takes one 512-bit block from local logic.

---
 rtl/sha1_avalon_master_if.sv | 19 +
 rtl/sha1_avalon_master.sv | 234 +++++++++++++++++++++++
 tb/tb_sha1_avalon_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_avalon_master_if.sv
// Avalon-MM bus between the SHA-1 block master and the SHA-1 register-file slave.
interface sha1_avalon_master_if;
    logic [31:0] avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_read, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_read, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/sha1_avalon_master.sv
// Avalon-MM master: loads one 512-bit block into the SHA-1 slave, starts it,
// polls for completion and reads back the 160-bit digest.
module sha1_avalon_master #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [511:0]                msg_block_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [159:0]                digest_o,
    sha1_avalon_master_if.master        avm
);
    localparam int unsigned PCW = ($clog2(TIMEOUT + 1) > 11) ? $clog2(TIMEOUT + 1) : 11;
    localparam int unsigned GW  = ($clog2(POLL_GAP + 1) > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [PCW-1:0] POLL_MAX = PCW'(TIMEOUT);
    localparam logic [GW-1:0]  GAP_LAST = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : {GW{1'b0}};

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_BLK    = 3'd1;
    localparam logic [2:0] S_WR_GO     = 3'd2;
    localparam logic [2:0] S_POLL_RD   = 3'd3;
    localparam logic [2:0] S_POLL_WAIT = 3'd4;
    localparam logic [2:0] S_RD_DIG    = 3'd5;
    localparam logic [2:0] S_CLR       = 3'd6;
    localparam logic [2:0] S_FIN       = 3'd7;

    logic [2:0]     state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           err_q, err_d;
    logic [511:0]   blk_q, blk_d;
    logic [159:0]   dig_buf_q, dig_buf_d;
    logic [159:0]   digest_q, digest_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    logic           xfer_s;
    logic [PCW-1:0] poll_inc_s;

    assign xfer_s     = (rd_q | wr_q) & ~avm.avm_waitrequest;
    assign poll_inc_s = (poll_cnt_q == {PCW{1'b1}}) ? poll_cnt_q
                                                    : poll_cnt_q + {{(PCW-1){1'b0}}, 1'b1};

    // Next-state and next-request logic; bus outputs are set up one edge ahead.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        poll_cnt_d = poll_cnt_q;
        gap_d      = gap_q;
        err_d      = err_q;
        blk_d      = blk_q;
        dig_buf_d  = dig_buf_q;
        digest_d   = digest_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !busy_q) begin
                    blk_d   = msg_block_i;
                    busy_d  = 1'b1;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                    wr_d    = 1'b1;
                    addr_d  = BASE_ADDR + 32'd1;
                    wdata_d = msg_block_i[511:480];
                    state_d = S_WR_BLK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_BLK: begin
                if (xfer_s && idx_q == 4'd15) begin
                    addr_d  = BASE_ADDR;
                    wdata_d = 32'h0000_0001;
                    state_d = S_WR_GO;
                end else if (xfer_s) begin
                    // Block is shifted so the next word is always in the top slot.
                    blk_d   = {blk_q[479:0], 32'h0000_0000};
                    wdata_d = blk_q[479:448];
                    addr_d  = BASE_ADDR + 32'd2 + {28'd0, idx_q};
                    idx_d   = idx_q + 4'd1;
                end else begin
                    state_d = S_WR_BLK;
                end
            end
            S_WR_GO: begin
                if (xfer_s) begin
                    wr_d       = 1'b0;
                    rd_d       = 1'b1;
                    addr_d     = BASE_ADDR;
                    wdata_d    = 32'h0000_0000;
                    poll_cnt_d = {PCW{1'b0}};
                    state_d    = S_POLL_RD;
                end else begin
                    state_d = S_WR_GO;
                end
            end
            S_POLL_RD: begin
                if (xfer_s) begin
                    poll_cnt_d = poll_inc_s;
                    if (avm.avm_readdata[1]) begin
                        idx_d   = 4'd0;
                        addr_d  = BASE_ADDR + 32'd17;
                        state_d = S_RD_DIG;
                    end else if (poll_inc_s == POLL_MAX) begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b1;
                        wdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                        state_d = S_CLR;
                    end else if (POLL_GAP == 0) begin
                        state_d = S_POLL_RD;
                    end else begin
                        rd_d    = 1'b0;
                        gap_d   = {GW{1'b0}};
                        state_d = S_POLL_WAIT;
                    end
                end else begin
                    state_d = S_POLL_RD;
                end
            end
            S_POLL_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    rd_d    = 1'b1;
                    state_d = S_POLL_RD;
                end else begin
                    gap_d = gap_q + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            S_RD_DIG: begin
                if (xfer_s && idx_q == 4'd4) begin
                    dig_buf_d = {dig_buf_q[127:0], avm.avm_readdata};
                    rd_d      = 1'b0;
                    wr_d      = 1'b1;
                    addr_d    = BASE_ADDR;
                    wdata_d   = 32'h0000_0000;
                    state_d   = S_CLR;
                end else if (xfer_s) begin
                    dig_buf_d = {dig_buf_q[127:0], avm.avm_readdata};
                    addr_d    = BASE_ADDR + 32'd18 + {28'd0, idx_q};
                    idx_d     = idx_q + 4'd1;
                end else begin
                    state_d = S_RD_DIG;
                end
            end
            S_CLR: begin
                if (xfer_s) begin
                    wr_d    = 1'b0;
                    state_d = S_FIN;
                end else begin
                    state_d = S_CLR;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (err_q) begin
                    error_d = 1'b1;
                end else begin
                    done_d   = 1'b1;
                    digest_d = dig_buf_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            poll_cnt_q <= {PCW{1'b0}};
            gap_q      <= {GW{1'b0}};
            err_q      <= 1'b0;
            blk_q      <= 512'd0;
            dig_buf_q  <= 160'd0;
            digest_q   <= 160'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            blk_q      <= blk_d;
            dig_buf_q  <= dig_buf_d;
            digest_q   <= digest_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign avm.avm_address   = addr_q;
    assign avm.avm_writedata = wdata_q;
    assign avm.avm_read      = rd_q;
    assign avm.avm_write     = wr_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign error_o           = error_q;
    assign digest_o          = digest_q;
endmodule

// File: tb/tb_sha1_avalon_master.sv
// Bench for sha1_avalon_master: behavioural SHA-1 register-file slave, random
// blocks and wait states, expected bus sequences built from the block contents.
module tb_sha1_avalon_master;
    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam int GAP = 2;
    localparam int TMO = 8;

    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} op_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] msg_block;
    logic         busy, done, error;
    logic [159:0] digest;
    sha1_avalon_master_if bus();

    sha1_avalon_master #(.BASE_ADDR(BASE), .POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start_i(start), .msg_block_i(msg_block),
        .busy_o(busy), .done_o(done), .error_o(error), .digest_o(digest),
        .avm(bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [159:0] sha1_blk(input logic [511:0] blk);
        logic [31:0] w [0:79];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                    k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                    k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c,
                32'h10325476 + d, 32'hC3D2E1F0 + e};
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = $urandom;
        return r;
    endfunction

    // ---------------- slave model ----------------
    logic [31:0]  sregs [0:31] = '{default: 32'h0};
    logic [31:0]  roff;
    logic [159:0] slave_dg;
    logic [65:0]  req_now, stalled_op;
    logic         stalled_q = 1'b0;
    bit           rand_wait, never_done, pend, clr_pulse;
    int           done_dly, dly, cyc, stall_viol, dig_cnt;
    op_t          ops[$];
    int           poll_t[$];

    assign roff     = bus.avm_address - BASE;
    assign bus.avm_readdata = (roff < 32'd22) ? sregs[roff[4:0]] : 32'hDEAD_BEEF;
    assign slave_dg = sha1_blk({sregs[1], sregs[2], sregs[3], sregs[4], sregs[5], sregs[6],
                                sregs[7], sregs[8], sregs[9], sregs[10], sregs[11], sregs[12],
                                sregs[13], sregs[14], sregs[15], sregs[16]});
    assign req_now  = {bus.avm_read, bus.avm_write, bus.avm_address,
                       bus.avm_write ? bus.avm_writedata : 32'h0};

    always @(negedge clk) bus.avm_waitrequest = rand_wait && ($urandom_range(1, 0) == 1);

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        clr_pulse  <= 1'b0;
        stalled_q  <= (bus.avm_read || bus.avm_write) && bus.avm_waitrequest && !reset;
        stalled_op <= req_now;
        if (!reset && bus.avm_read && bus.avm_write) stall_viol <= stall_viol + 1;
        else if (!reset && stalled_q && req_now != stalled_op) stall_viol <= stall_viol + 1;
        if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
            ops.push_back('{bus.avm_write, bus.avm_address,
                            bus.avm_write ? bus.avm_writedata : bus.avm_readdata});
            if (bus.avm_read && roff == 32'd0) poll_t.push_back(cyc);
            if (bus.avm_read && roff >= 32'd17 && roff <= 32'd21) dig_cnt <= dig_cnt + 1;
            if (bus.avm_write && roff < 32'd22) begin
                if (roff == 32'd0 && bus.avm_writedata[0]) begin
                    sregs[0]  <= bus.avm_writedata | ((done_dly == 0 && !never_done) ? 32'd2 : 32'd0);
                    sregs[17] <= slave_dg[159:128];
                    sregs[18] <= slave_dg[127:96];
                    sregs[19] <= slave_dg[95:64];
                    sregs[20] <= slave_dg[63:32];
                    sregs[21] <= slave_dg[31:0];
                    pend      <= (done_dly != 0) && !never_done;
                    dly       <= done_dly - 1;
                end else begin
                    sregs[roff[4:0]] <= bus.avm_writedata;
                end
                if (roff == 32'd0 && bus.avm_writedata == 32'd0) clr_pulse <= 1'b1;
            end
        end
        if (pend) begin
            if (dly == 0) begin sregs[0] <= sregs[0] | 32'd2; pend <= 1'b0; end
            else dly <= dly - 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [511:0] m);
        msg_block = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_end(input bit disturb, input bit chain, input logic [511:0] nxt, output int n);
        logic [31:0] r;
        n = 0;
        while (n < 4000) begin
            @(negedge clk);
            n++;
            if (done || error) break;
            if (disturb) begin
                r = $urandom;
                start = r[0];
                msg_block = {16{r}};
            end
            if (chain && clr_pulse) begin
                start = 1'b1;
                msg_block = nxt;
            end
        end
        if (!chain) start = 1'b0;
        check_eq("end_seen", (done || error), 1'b1);
    endtask

    task automatic check_ops(input int base, input logic [511:0] m, input bit err, input int exp_polls);
        op_t got[$];
        op_t exp[$];
        int polls;
        logic [159:0] dg;
        polls = 0;
        dg = sha1_blk(m);
        for (int i = base; i < ops.size(); i++) begin
            if (!ops[i].wr && ops[i].addr == BASE) polls++;
            else got.push_back(ops[i]);
        end
        for (int i = 0; i < 16; i++) exp.push_back('{1'b1, BASE + 32'd1 + 32'(i), m[511-32*i -: 32]});
        exp.push_back('{1'b1, BASE, 32'd1});
        if (!err) for (int i = 0; i < 5; i++) exp.push_back('{1'b0, BASE + 32'd17 + 32'(i), dg[159-32*i -: 32]});
        exp.push_back('{1'b1, BASE, 32'd0});
        check_eq("op_count", got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check_eq($sformatf("op%0d", i), (i < got.size()) ? got[i] : op_t'(0), exp[i]);
        if (exp_polls >= 0) check_eq("poll_count", polls, exp_polls);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [511:0] abc, m, m2;
        logic [159:0] old;
        int n, base, base2, pbase, bad, b;

        abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
        reset = 1'b1; start = 1'b0; msg_block = 512'd0; done_dly = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_digest", digest, 160'd0);
        check_eq("rst_read", bus.avm_read, 1'b0);
        check_eq("rst_write", bus.avm_write, 1'b0);
        check_eq("rst_addr", bus.avm_address, 32'd0);
        check_eq("rst_wdata", bus.avm_writedata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Known-answer block, zero wait states, done seen on the first poll.
        base = ops.size();
        launch(abc);
        wait_end(1'b0, 1'b0, 512'd0, n);
        check_eq("abc_done", done, 1'b1);
        check_eq("abc_busy_low", busy, 1'b0);
        check_eq("abc_latency", n, 25);
        check_eq("abc_digest_kat", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        check_eq("abc_digest_model", digest, sha1_blk(abc));
        check_ops(base, abc, 1'b0, 1);
        @(negedge clk);
        check_eq("done_one_cycle", done, 1'b0);

        // Random blocks under random wait states and slave delays.
        rand_wait = 1'b1;
        for (int t = 0; t < 3; t++) begin
            m = rand_blk();
            done_dly = $urandom_range(6, 0);
            base = ops.size();
            launch(m);
            wait_end(1'b0, 1'b0, 512'd0, n);
            check_eq("rw_done", done, 1'b1);
            check_eq("rw_digest", digest, sha1_blk(m));
            check_ops(base, m, 1'b0, -1);
        end
        check_eq("stall_stable", stall_viol, 0);
        rand_wait = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Slave never completes: poll timeout.
        never_done = 1'b1;
        old = digest;
        m = rand_blk();
        base = ops.size();
        pbase = poll_t.size();
        launch(m);
        wait_end(1'b0, 1'b0, 512'd0, n);
        check_eq("to_error", error, 1'b1);
        check_eq("to_no_done", done, 1'b0);
        check_eq("to_digest_kept", digest, old);
        check_ops(base, m, 1'b1, TMO);
        bad = 0;
        for (int i = pbase + 1; i < poll_t.size(); i++) if (poll_t[i] - poll_t[i-1] != GAP + 1) bad++;
        check_eq("poll_spacing", bad, 0);
        @(negedge clk);
        check_eq("error_one_cycle", error, 1'b0);
        never_done = 1'b0;

        // Start pulses and message changes while busy must be ignored.
        done_dly = 3;
        m = rand_blk();
        base = ops.size();
        launch(m);
        wait_end(1'b1, 1'b0, 512'd0, n);
        check_eq("dist_done", done, 1'b1);
        check_eq("dist_digest", digest, sha1_blk(m));
        check_ops(base, m, 1'b0, -1);
        @(negedge clk);
        check_eq("dist_idle", busy, 1'b0);

        // Reset while reading the digest.
        done_dly = 0;
        m = rand_blk();
        b = dig_cnt;
        launch(m);
        n = 0;
        while (dig_cnt == b && n < 200) begin @(negedge clk); n++; end
        check_eq("rd_dig_reached", (dig_cnt != b), 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_read", bus.avm_read, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_digest", digest, 160'd0);
        bad = 0;
        repeat (4) begin @(negedge clk); if (bus.avm_read || bus.avm_write) bad++; end
        check_eq("mid_rst_quiet", bad, 0);
        m = rand_blk();
        base = ops.size();
        launch(m);
        wait_end(1'b0, 1'b0, 512'd0, n);
        check_eq("post_rst_digest", digest, sha1_blk(m));
        check_ops(base, m, 1'b0, 1);

        // Back-to-back: start held from the FIN cycle into the done cycle.
        m = rand_blk();
        m2 = rand_blk();
        base = ops.size();
        launch(m);
        wait_end(1'b0, 1'b1, m2, n);
        check_eq("b2b_first_done", done, 1'b1);
        check_eq("b2b_first_digest", digest, sha1_blk(m));
        check_ops(base, m, 1'b0, 1);
        base2 = ops.size();
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_second_busy", busy, 1'b1);
        wait_end(1'b0, 1'b0, 512'd0, n);
        check_eq("b2b_second_done", done, 1'b1);
        check_eq("b2b_second_latency", n, 25);
        check_eq("b2b_second_digest", digest, sha1_blk(m2));
        check_ops(base2, m2, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
